fifo_coder: RTL and testbench
=============================

Name: fifo_coder

Overview:
- Synchronous single-clock FIFO buffering 32-bit words produced by the Huffman coder's bit packer until the host reads them.
- First-word-fall-through: the head word is always visible on data_out, so the consumer samples data_out on the same edge at which it pops with rd.
- Provides full, empty and threshold status plus sticky overflow/underflow error flags.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 16, number of storage words; must be a power of two.
- ADDR_W, 4, pointer width; log2(DEPTH).
- THRESHOLD, 8, occupancy level at or above which fifo_threshold is asserted; range 1..DEPTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- wr  in  1  write request; data_in is stored at the rising edge when accepted.
- rd  in  1  read/pop request; the head word is removed at the rising edge when accepted.
- data_in  in  WIDTH  word to write.
- data_out  out  WIDTH  current head word (combinational from mem[rd_ptr]).
- fifo_full  out  1  count == DEPTH.
- fifo_empty  out  1  count == 0.
- fifo_threshold  out  1  count >= THRESHOLD.
- fifo_overflow  out  1  sticky: a write was attempted and rejected because the FIFO was full.
- fifo_underflow  out  1  sticky: a read was attempted and rejected because the FIFO was empty.

Behaviour:
- State: mem[DEPTH] of WIDTH bits; wr_ptr and rd_ptr (ADDR_W bits each, wrap modulo DEPTH); count (ADDR_W+1 bits, 0..DEPTH).
- Reset (rst_n low, asynchronous): wr_ptr = 0, rd_ptr = 0, count = 0, fifo_overflow = 0, fifo_underflow = 0.
  - Consequently fifo_empty = 1, fifo_full = 0, fifo_threshold = 0.
  - mem is not cleared; data_out is don't-care while the FIFO is empty.
- Status flags fifo_full, fifo_empty and fifo_threshold are combinational decodes of count, so they are valid in the cycle after the causing edge.
- Accept rules, evaluated on the pre-edge count:
  - write_ok = wr & (~full | rd).
  - read_ok = rd & ~empty.
- On write_ok: mem[wr_ptr] <= data_in; wr_ptr increments.
- On read_ok: rd_ptr increments.
- count update: +1 if write_ok only; -1 if read_ok only; unchanged if both or neither.
- Simultaneous wr and rd:
  - When full: both are accepted, count stays DEPTH, and the old head is replaced by the next word.
  - When empty: only the write is accepted; rd is ignored and fifo_underflow is set.
  - Otherwise: both are accepted.
- Error flags:
  - wr & ~write_ok sets fifo_overflow; the word is dropped and no state changes.
  - rd & ~read_ok sets fifo_underflow; pointers are unchanged.
  - Both flags remain set until reset.
- Pointer wrap is natural modulo DEPTH; there is no special handling at the wrap boundary.
- Latency:
  - A word written at edge N appears on data_out after edge N if the FIFO was empty.
  - data_out changes only after a pop, or after the first write into an empty FIFO.

Test Plan:
- Reset, then write 0x00000001, 0x00000002, 0x00000003 on consecutive cycles -> fifo_empty = 0 after the first edge and data_out = 0x00000001; three rd cycles present 1, 2, 3 then fifo_empty = 1; both error flags remain 0.
- Write 16 words 0xA0000000+i -> fifo_threshold rises after the 8th write and fifo_full after the 16th; a 17th write sets fifo_overflow and the contents are unchanged; draining 16 words returns 0xA0000000..0xA000000F in order.
- On an empty FIFO assert rd alone -> fifo_underflow = 1, fifo_empty stays 1; assert rd together with wr of 0x55 -> count becomes 1 and data_out = 0x55.
- Fill to full, then hold rd and wr together for 20 cycles with an incrementing pattern -> fifo_full stays 1 and no overflow; read order is preserved across pointer wrap.
- Mid-stream with 5 words stored, pulse rst_n low asynchronously between edges -> fifo_empty = 1 and all other flags = 0 immediately, without waiting for a clock edge; the next write/read pair returns the new word.

Source files
------------

// File: rtl/fifo_coder_if.sv
// -----------------------------------------------------------------------------
// fifo_coder_if
// Handshake/data bundle between the Huffman bit packer / host and fifo_coder.
//
// Signals:
//   wr, rd          write and pop requests (driven by master)
//   data_in         word to write (driven by master)
//   data_out        current head word (driven by slave, valid when not empty)
//   fifo_full       occupancy == DEPTH
//   fifo_empty      occupancy == 0
//   fifo_threshold  occupancy >= THRESHOLD
//   fifo_overflow   sticky: a write was rejected because the FIFO was full
//   fifo_underflow  sticky: a read was rejected because the FIFO was empty
//
// Modports:
//   master  producer/consumer side (bench or host logic)
//   slave   the FIFO itself
// -----------------------------------------------------------------------------
interface fifo_coder_if #(
  parameter int WIDTH = 32
);
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_threshold;
  logic             fifo_overflow;
  logic             fifo_underflow;

  modport master (
    output wr, rd, data_in,
    input  data_out, fifo_full, fifo_empty, fifo_threshold,
           fifo_overflow, fifo_underflow
  );

  modport slave (
    input  wr, rd, data_in,
    output data_out, fifo_full, fifo_empty, fifo_threshold,
           fifo_overflow, fifo_underflow
  );
endinterface : fifo_coder_if

// File: rtl/fifo_coder.sv
// -----------------------------------------------------------------------------
// fifo_coder
// Single-clock first-word-fall-through FIFO that buffers 32-bit words from the
// Huffman coder's bit packer until the host reads them. The head word is
// always presented on data_out, so the consumer samples it on the same edge
// at which it pops with rd.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    fifo_coder_if.slave: wr/rd/data_in in, data_out and status out
//
// Parameters:
//   WIDTH      data word width
//   DEPTH      storage words, power of two
//   ADDR_W     log2(DEPTH)
//   THRESHOLD  occupancy at or above which fifo_threshold asserts (1..DEPTH)
// -----------------------------------------------------------------------------
module fifo_coder #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int THRESHOLD = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  fifo_coder_if.slave  bus
);

  localparam logic [ADDR_W:0] C_DEPTH  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] C_THRESH = (ADDR_W + 1)'(THRESHOLD);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  logic              w_write_ok;
  logic              w_read_ok;

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // A full FIFO still takes a write when a pop frees the head slot in the
  // same cycle; an empty FIFO never pops, even if a write arrives alongside.
  assign w_write_ok = bus.wr & (~w_full | bus.rd);
  assign w_read_ok  = bus.rd & ~w_empty;

  // NOTE: storage is deliberately left out of reset; data_out is don't-care
  // while empty, and a resettable array would cost a reset net per bit.
  always_ff @(posedge clk) begin
    if (w_write_ok) begin
      r_mem[r_wr_ptr] <= bus.data_in;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_write_ok) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_read_ok) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      // Simultaneous accepted write and read leave the occupancy unchanged.
      if (w_write_ok && !w_read_ok) begin
        r_count <= r_count + (ADDR_W + 1)'(1);
      end else if (w_read_ok && !w_write_ok) begin
        r_count <= r_count - (ADDR_W + 1)'(1);
      end
      if (bus.wr && !w_write_ok) begin
        r_overflow <= 1'b1;
      end
      if (bus.rd && !w_read_ok) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign bus.data_out       = r_mem[r_rd_ptr];
  assign bus.fifo_full      = w_full;
  assign bus.fifo_empty     = w_empty;
  assign bus.fifo_threshold = (r_count >= C_THRESH);
  assign bus.fifo_overflow  = r_overflow;
  assign bus.fifo_underflow = r_underflow;

endmodule : fifo_coder

// File: tb/tb_fifo_coder.sv
// -----------------------------------------------------------------------------
// tb_fifo_coder
// Directed self-checking bench for fifo_coder. Inputs change 1 ns after each
// rising edge and outputs are sampled there too, away from the active edge.
// -----------------------------------------------------------------------------
module tb_fifo_coder;

  localparam int WIDTH     = 32;
  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 4;
  localparam int THRESHOLD = 8;

  logic clk;
  logic rst_n;

  fifo_coder_if #(.WIDTH(WIDTH)) bus ();

  fifo_coder #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .THRESHOLD(THRESHOLD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flags_idle(input string tag);
    check({tag, " empty"},     32'(bus.fifo_empty),     32'd1);
    check({tag, " full"},      32'(bus.fifo_full),      32'd0);
    check({tag, " threshold"}, 32'(bus.fifo_threshold), 32'd0);
    check({tag, " overflow"},  32'(bus.fifo_overflow),  32'd0);
    check({tag, " underflow"}, 32'(bus.fifo_underflow), 32'd0);
  endtask

  // Synchronous-style reset pulse aligned to the bench's sampling point.
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.data_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ---- reset state
    flags_idle("reset");

    // ---- basic write 1,2,3 then read back
    bus.wr = 1'b1; bus.data_in = 32'h0000_0001;
    tick();
    check("w1 empty", 32'(bus.fifo_empty), 32'd0);
    check("w1 head",  bus.data_out,        32'h0000_0001);
    bus.data_in = 32'h0000_0002;
    tick();
    bus.data_in = 32'h0000_0003;
    tick();
    bus.wr = 1'b0;
    check("w3 head unchanged", bus.data_out, 32'h0000_0001);
    bus.rd = 1'b1;
    tick();
    check("r1 head", bus.data_out, 32'h0000_0002);
    tick();
    check("r2 head", bus.data_out, 32'h0000_0003);
    tick();
    bus.rd = 1'b0;
    check("r3 empty",     32'(bus.fifo_empty),     32'd1);
    check("r3 overflow",  32'(bus.fifo_overflow),  32'd0);
    check("r3 underflow", 32'(bus.fifo_underflow), 32'd0);

    // ---- fill to full, threshold and full boundaries
    bus.wr = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.data_in = 32'hA000_0000 + 32'(i);
      tick();
      if (i == THRESHOLD - 2) check("thr below", 32'(bus.fifo_threshold), 32'd0);
      if (i == THRESHOLD - 1) check("thr at",    32'(bus.fifo_threshold), 32'd1);
      if (i == DEPTH - 2)     check("full below", 32'(bus.fifo_full),     32'd0);
      if (i == DEPTH - 1)     check("full at",    32'(bus.fifo_full),     32'd1);
    end
    check("full no overflow", 32'(bus.fifo_overflow), 32'd0);
    bus.data_in = 32'hDEAD_BEEF;
    tick();
    bus.wr = 1'b0;
    check("17th overflow", 32'(bus.fifo_overflow), 32'd1);
    check("17th full",     32'(bus.fifo_full),     32'd1);
    check("17th head",     bus.data_out,           32'hA000_0000);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain %0d", i), bus.data_out, 32'hA000_0000 + 32'(i));
      bus.rd = 1'b1;
      tick();
      bus.rd = 1'b0;
      if (i == DEPTH - THRESHOLD - 1) check("thr still", 32'(bus.fifo_threshold), 32'd1);
      if (i == DEPTH - THRESHOLD)     check("thr fall",  32'(bus.fifo_threshold), 32'd0);
    end
    check("drain empty",    32'(bus.fifo_empty),    32'd1);
    check("drain overflow", 32'(bus.fifo_overflow), 32'd1);

    // ---- underflow and rd+wr on empty
    do_reset();
    flags_idle("reset2");
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    check("uf set",   32'(bus.fifo_underflow), 32'd1);
    check("uf empty", 32'(bus.fifo_empty),     32'd1);
    bus.rd = 1'b1; bus.wr = 1'b1; bus.data_in = 32'h0000_0055;
    tick();
    bus.rd = 1'b0; bus.wr = 1'b0;
    check("rdwr empty flag", 32'(bus.fifo_empty),    32'd0);
    check("rdwr head",       bus.data_out,           32'h0000_0055);
    check("rdwr overflow",   32'(bus.fifo_overflow), 32'd0);
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    check("rdwr count was 1", 32'(bus.fifo_empty), 32'd1);

    // ---- full with continuous rd+wr across pointer wrap
    do_reset();
    model_q.delete();
    bus.wr = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.data_in = 32'h0000_0100 + 32'(i);
      model_q.push_back(bus.data_in);
      tick();
    end
    check("stream full", 32'(bus.fifo_full), 32'd1);
    bus.rd = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.data_in = 32'h0000_0200 + 32'(k);
      check($sformatf("stream head %0d", k), bus.data_out, model_q.pop_front());
      model_q.push_back(bus.data_in);
      tick();
      check($sformatf("stream full %0d", k), 32'(bus.fifo_full), 32'd1);
    end
    bus.wr = 1'b0;
    check("stream overflow", 32'(bus.fifo_overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("wrap drain %0d", i), bus.data_out, model_q.pop_front());
      tick();
    end
    bus.rd = 1'b0;
    check("wrap drain empty", 32'(bus.fifo_empty),     32'd1);
    check("wrap underflow",   32'(bus.fifo_underflow), 32'd0);

    // ---- asynchronous reset mid-stream
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    check("pre-rst underflow", 32'(bus.fifo_underflow), 32'd1);
    bus.wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.data_in = 32'h0000_0300 + 32'(i);
      tick();
    end
    bus.wr = 1'b0;
    check("pre-rst empty", 32'(bus.fifo_empty), 32'd0);
    // Assert and sample between edges: no clock edge occurs in this window.
    #2 rst_n = 1'b0;
    #1;
    flags_idle("async rst");
    #1 rst_n = 1'b1;
    tick();
    bus.wr = 1'b1; bus.data_in = 32'h0000_0077;
    tick();
    bus.wr = 1'b0;
    check("post-rst head",  bus.data_out,        32'h0000_0077);
    check("post-rst empty", 32'(bus.fifo_empty), 32'd0);
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    check("post-rst drain",     32'(bus.fifo_empty),     32'd1);
    check("post-rst underflow", 32'(bus.fifo_underflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fifo_coder
